// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: PC controls, instruction ROM port, redirect request and
// the valid/ready instruction stream towards decode.
interface instruction_fetch_if;
  logic [15:0] pc;
  logic        pc_increment;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        jump_valid;
  logic [15:0] jump_target;
  logic [15:0] instr;
  logic [15:0] instr_addr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    input  pc, rom_data, jump_valid, jump_target, instr_ready,
    output pc_increment, pc_load, pc_load_value, rom_addr,
           instr, instr_addr, instr_valid
  );

  modport slave (
    output pc, rom_data, jump_valid, jump_target, instr_ready,
    input  pc_increment, pc_load, pc_load_value, rom_addr,
           instr, instr_addr, instr_valid
  );
endinterface

// File: rtl/instruction_fetch.sv
// Hack CPU fetch stage: issues PC increments against a registered ROM and
// buffers returning words in an output register plus one skid entry.
module instruction_fetch (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master fetchBus
);

  logic        outValid_q, outValid_d;
  logic [15:0] outInstr_q, outInstr_d;
  logic [15:0] outAddr_q, outAddr_d;
  logic        skidValid_q, skidValid_d;
  logic [15:0] skidInstr_q, skidInstr_d;
  logic [15:0] skidAddr_q, skidAddr_d;
  logic        inflight_q, inflight_d;
  logic [15:0] inflightAddr_q, inflightAddr_d;

  logic        consume;
  logic        issue;
  logic [1:0]  occ;
  logic [1:0]  occAfter;

  assign consume  = outValid_q & fetchBus.instr_ready;
  assign occ      = {1'b0, outValid_q} + {1'b0, skidValid_q} + {1'b0, inflight_q};
  assign occAfter = occ - {1'b0, consume};
  // Only issue when the returning word is guaranteed a slot next cycle.
  assign issue    = !reset && !fetchBus.jump_valid && (occAfter < 2'd2);

  assign fetchBus.pc_increment  = issue;
  assign fetchBus.pc_load       = !reset && fetchBus.jump_valid;
  assign fetchBus.pc_load_value = reset ? 16'h0000 : fetchBus.jump_target;
  assign fetchBus.rom_addr      = fetchBus.pc;
  assign fetchBus.instr         = outInstr_q;
  assign fetchBus.instr_addr    = outAddr_q;
  assign fetchBus.instr_valid   = outValid_q;

  always_comb begin
    outValid_d     = outValid_q;
    outInstr_d     = outInstr_q;
    outAddr_d      = outAddr_q;
    skidValid_d    = skidValid_q;
    skidInstr_d    = skidInstr_q;
    skidAddr_d     = skidAddr_q;
    inflight_d     = issue;
    inflightAddr_d = issue ? fetchBus.pc : inflightAddr_q;

    if (fetchBus.jump_valid) begin
      outValid_d  = 1'b0;
      skidValid_d = 1'b0;
    end else begin
      if (consume) begin
        if (skidValid_q) begin
          outValid_d  = 1'b1;
          outInstr_d  = skidInstr_q;
          outAddr_d   = skidAddr_q;
          skidValid_d = 1'b0;
        end else begin
          outValid_d  = 1'b0;
        end
      end
      // Returning word lands behind whatever the consume step left in OUT.
      if (inflight_q) begin
        if (!outValid_d) begin
          outValid_d  = 1'b1;
          outInstr_d  = fetchBus.rom_data;
          outAddr_d   = inflightAddr_q;
        end else begin
          skidValid_d = 1'b1;
          skidInstr_d = fetchBus.rom_data;
          skidAddr_d  = inflightAddr_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q     <= 1'b0;
      outInstr_q     <= 16'h0000;
      outAddr_q      <= 16'h0000;
      skidValid_q    <= 1'b0;
      skidInstr_q    <= 16'h0000;
      skidAddr_q     <= 16'h0000;
      inflight_q     <= 1'b0;
      inflightAddr_q <= 16'h0000;
    end else begin
      outValid_q     <= outValid_d;
      outInstr_q     <= outInstr_d;
      outAddr_q      <= outAddr_d;
      skidValid_q    <= skidValid_d;
      skidInstr_q    <= skidInstr_d;
      skidAddr_q     <= skidAddr_d;
      inflight_q     <= inflight_d;
      inflightAddr_q <= inflightAddr_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural PC and a registered
// ROM holding ROM[a] = a + 0x1000.
module tb_instruction_fetch;

  logic clk;
  logic reset;
  int   errorCount;
  int   checkCount;
  logic [15:0] pcReg;
  logic [15:0] romReg;

  instruction_fetch_if ifc ();

  instruction_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .fetchBus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ifc.pc       = pcReg;
  assign ifc.rom_data = romReg;

  // Environment: program counter and synchronous instruction ROM.
  always @(posedge clk) begin
    if (reset)
      pcReg <= 16'h0000;
    else if (ifc.pc_load)
      pcReg <= ifc.pc_load_value;
    else if (ifc.pc_increment)
      pcReg <= pcReg + 16'h0001;
    romReg <= ifc.rom_addr + 16'h1000;
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic jv,
                               input logic [15:0] tgt);
    reset           = rst;
    ifc.instr_ready = rdy;
    ifc.jump_valid  = jv;
    ifc.jump_target = tgt;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectEntry(input string tag, input logic [15:0] addr);
    checkOutput({tag, "_valid"}, 16'(ifc.instr_valid), 16'h0001);
    checkOutput({tag, "_addr"}, ifc.instr_addr, addr);
    checkOutput({tag, "_instr"}, ifc.instr, addr + 16'h1000);
  endtask

  initial begin
    errorCount = 0;
    checkCount = 0;

    // Reset held, with a jump request that must be masked.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234);
    repeat (3) nextCycle();
    checkOutput("rst_valid", 16'(ifc.instr_valid), 16'h0000);
    checkOutput("rst_instr", ifc.instr, 16'h0000);
    checkOutput("rst_addr", ifc.instr_addr, 16'h0000);
    checkOutput("rst_inc", 16'(ifc.pc_increment), 16'h0000);
    checkOutput("rst_load", 16'(ifc.pc_load), 16'h0000);
    checkOutput("rst_loadval", ifc.pc_load_value, 16'h0000);

    // Startup: cycles 0..2.
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("c0_inc", 16'(ifc.pc_increment), 16'h0001);
    checkOutput("c0_romaddr", ifc.rom_addr, 16'h0000);
    checkOutput("c0_valid", 16'(ifc.instr_valid), 16'h0000);
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("c1_valid", 16'(ifc.instr_valid), 16'h0000);
    checkOutput("c1_inc", 16'(ifc.pc_increment), 16'h0001);
    checkOutput("c1_romaddr", ifc.rom_addr, 16'h0001);
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    expectEntry("c2", 16'h0000);
    checkOutput("c2_inc", 16'(ifc.pc_increment), 16'h0001);

    // Back-pressure from cycle 3 for five cycles.
    for (int i = 3; i < 8; i++) begin
      nextCycle(); applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      expectEntry("stall", 16'h0001);
      checkOutput("stall_inc", 16'(ifc.pc_increment), 16'h0000);
      checkOutput("stall_pc", ifc.rom_addr, 16'h0003);
    end

    // Release: 1, 2, 3, 4 back to back.
    for (int i = 1; i < 5; i++) begin
      nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      expectEntry("drain", 16'(i));
      checkOutput("drain_inc", 16'(ifc.pc_increment), 16'h0001);
    end

    // Fill OUT and SKID, then jump while both are held.
    nextCycle(); applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    expectEntry("fill", 16'h0005);
    checkOutput("fill_inc", 16'(ifc.pc_increment), 16'h0000);
    nextCycle(); applyStimulus(1'b0, 1'b0, 1'b1, 16'h0040);
    expectEntry("jmp1_held", 16'h0005);
    checkOutput("jmp1_load", 16'(ifc.pc_load), 16'h0001);
    checkOutput("jmp1_loadval", ifc.pc_load_value, 16'h0040);
    checkOutput("jmp1_inc", 16'(ifc.pc_increment), 16'h0000);
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("jmp1_t1_valid", 16'(ifc.instr_valid), 16'h0000);
    checkOutput("jmp1_t1_pc", ifc.rom_addr, 16'h0040);
    checkOutput("jmp1_t1_inc", 16'(ifc.pc_increment), 16'h0001);
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("jmp1_t2_valid", 16'(ifc.instr_valid), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      expectEntry("tgt", 16'h0040 + 16'(i));
    end

    // Jump coincident with consume of 0x43; 0x44 must never show up.
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFE);
    expectEntry("jmp2_consume", 16'h0043);
    checkOutput("jmp2_inc", 16'(ifc.pc_increment), 16'h0000);
    checkOutput("jmp2_load", 16'(ifc.pc_load), 16'h0001);
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("jmp2_t1_valid", 16'(ifc.instr_valid), 16'h0000);
    checkOutput("jmp2_t1_pc", ifc.rom_addr, 16'hFFFE);
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("jmp2_t2_valid", 16'(ifc.instr_valid), 16'h0000);
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    expectEntry("wrap0", 16'hFFFE);
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    expectEntry("wrap1", 16'hFFFF);
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    expectEntry("wrap2", 16'h0000);

    // One-cycle reset while an entry is valid and a fetch is in flight.
    nextCycle(); applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    expectEntry("mid_rst", 16'h0001);
    checkOutput("mid_rst_inc", 16'(ifc.pc_increment), 16'h0000);
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("re_c0_valid", 16'(ifc.instr_valid), 16'h0000);
    checkOutput("re_c0_instr", ifc.instr, 16'h0000);
    checkOutput("re_c0_pc", ifc.rom_addr, 16'h0000);
    checkOutput("re_c0_inc", 16'(ifc.pc_increment), 16'h0001);
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("re_c1_valid", 16'(ifc.instr_valid), 16'h0000);
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    expectEntry("re_c2", 16'h0000);
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    expectEntry("re_c3", 16'h0001);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
